cbus_arbiter: RTL

Shares one downstream cache bus (CBus) between several cache-side requesters, typically the ICache refill port and the DCache refill/writeback port. Sequences whole bursts: one requester is granted and holds the bus until its burst completes with `last`, then the bus is re-arbitrated. Sits between the L1 caches and the memory-side CBus-to-AXI bridge.

---
 rtl/cbus_arbiter_pkg.sv | 38 +++
 rtl/cbus_arb_picker.sv | 41 ++++
 rtl/cbus_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types plus the arbiter FSM state enum.
// Used by cbus_arbiter (optional macro CBUS_ARB_RR_EN selects round-robin).
package cbus_arbiter_pkg;

  typedef enum logic [2:0] {
    MLEN1  = 3'd0,
    MLEN2  = 3'd1,
    MLEN4  = 3'd2,
    MLEN8  = 3'd3,
    MLEN16 = 3'd4
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    cbus_len_t   len;
    logic [3:0]  strb;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } cbus_arb_state_t;

  // Beats in a burst of the given encoded length.
  function automatic int unsigned mlen_beats(input cbus_len_t len);
    return 32'd1 << len;
  endfunction

endpackage

// File: rtl/cbus_arb_picker.sv
// Combinational winner selection for cbus_arbiter.
// CBUS_ARB_RR_EN: round-robin from last_grant+1; otherwise lowest index wins.
module cbus_arb_picker
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_BITS-1:0]   last_grant,
  output logic [IDX_BITS-1:0]   winner,
  output logic                  any_valid
);

  assign any_valid = |valid;

`ifdef CBUS_ARB_RR_EN
  int idx;

  // Walk the ring farthest-first so the nearest valid requester overwrites last.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_INPUTS;
      if (valid[idx]) winner = IDX_BITS'(idx);
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    winner = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (valid[i]) winner = IDX_BITS'(i);
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Burst-granular arbiter sharing one CBus among NUM_INPUTS cache requesters.
// Macro CBUS_ARB_RR_EN: round-robin picker with a last_grant pointer.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  cbus_req_t           ireqs  [NUM_INPUTS],
  output cbus_resp_t          oresps [NUM_INPUTS],
  output cbus_req_t           oreq,
  input  cbus_resp_t          oresp,
  output logic                busy,
  output logic [IDX_BITS-1:0] grant_idx
);

  cbus_arb_state_t       state;
  logic [NUM_INPUTS-1:0] valid_vec;
  logic [IDX_BITS-1:0]   winner;
  logic [IDX_BITS-1:0]   last_grant;
  logic                  any_valid;
  logic                  burst_done;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_valid
    assign valid_vec[i] = ireqs[i].valid;
  end

  cbus_arb_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_BITS   (IDX_BITS)
  ) u_picker (
    .valid      (valid_vec),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  assign burst_done = oresp.ready & oresp.last;

  // Grant is sticky for the whole burst; only last releases it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      busy      <= 1'b0;
      grant_idx <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            state     <= ARB_BUSY;
            busy      <= 1'b1;
            grant_idx <= winner;
          end
        end
        ARB_BUSY: begin
          if (burst_done) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CBUS_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             last_grant <= '0;
    else if (state == ARB_IDLE && any_valid) last_grant <= winner;
  end
`else
  assign last_grant = '0;
`endif

  always_comb begin
    oreq = '0;
    if (state == ARB_BUSY) oreq = ireqs[grant_idx];
  end

  // Non-owners see all-zero responses so they cannot mistake another burst's beats.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_resp
    assign oresps[i] = (state == ARB_BUSY && grant_idx == IDX_BITS'(i)) ? oresp : '0;
  end

endmodule
